// File: rtl/cla_nibble_seq_adder.sv
// Purpose: WIDTH-bit adder, one 4-bit carry-lookahead slice per clock, nibble 0 first.
// Latency: out_valid N=WIDTH/4 cycles after acceptance; N+2 cycles per op with out_ready high.
// Backpressure: in_ready low in RUN/DONE; result held stable in DONE until out_ready.
// Optional: define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [IDXW-1:0]  r_idx;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_p;
    logic [3:0]       w_g;
    logic             w_c1;
    logic             w_c2;
    logic             w_c3;
    logic             w_c4;
    logic [3:0]       w_sum_nib;
`ifdef CLA_SEQ_OVF_EN
    logic             r_ovf;
`endif

    assign w_last = (r_idx == IDXW'(N - 1));

    // Select the operand nibbles addressed by the nibble index (constant-index mux).
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end
        end
    end

    // 4-bit carry-lookahead slice: all carries derived directly from p/g and the carry register.
    always_comb begin
        w_p  = w_a_nib ^ w_b_nib;
        w_g  = w_a_nib & w_b_nib;
        w_c1 = w_g[0] | (w_p[0] & r_carry);
        w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_sum_nib = w_p ^ {w_c3, w_c2, w_c1, r_carry};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; handshake outputs decode only the registered state.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble sum write-back, carry chaining and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
`ifdef CLA_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                for (int i = 0; i < N; i++) begin
                    if (r_idx == IDXW'(i)) begin
                        r_sum[4*i +: 4] <= w_sum_nib;
                    end
                end
                r_carry <= w_c4;
                if (w_last) begin
                    r_idx  <= '0;
                    r_cout <= w_c4;
`ifdef CLA_SEQ_OVF_EN
                    r_ovf  <= w_c3 ^ w_c4;
`endif
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef CLA_SEQ_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Bench for cla_nibble_seq_adder (WIDTH=16): directed corner cases, backpressure,
// mid-operation reset, then randomized traffic against an arithmetic reference model
// with an in-order scoreboard.
module tb_cla_nibble_seq_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef CLA_SEQ_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    cla_nibble_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition plus the two's-complement overflow rule.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [W-1:0] s);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    // One complete operation with a hostile in_valid pulse during RUN and `hold`
    // cycles of out_ready=0 in DONE before the result is taken.
    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input int hold, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        chk({tag, "_in_ready_wait"}, {31'd0, in_ready}, 32'd1);
        a         = ai;
        b         = bi;
        cin       = ci;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        a   = ~ai;
        b   = bi ^ 16'hA5A5;
        cin = ~ci;
        chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        chk({tag, "_in_ready_run"}, {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
            in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, lat, N);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef CLA_SEQ_OVF_EN
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_hold_sum"}, {16'd0, sum}, {16'd0, es});
            chk({tag, "_hold_cout"}, {31'd0, cout}, {31'd0, ec});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_post_sum"}, {16'd0, sum}, {16'd0, es});
    endtask

    logic [W:0]   exp_q[$];
    logic         exp_ovf_q[$];
    logic [W:0]   r;
    logic [W:0]   e;
    logic         eo;
    int           n_in;
    int           n_out;
    int           cyc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        step();

        run_op("basic",   16'h1234, 16'h4321, 1'b1, 0, 16'h5556, 1'b0, 1'b0);
        run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 3, 16'h0000, 1'b1, 1'b0);
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 2, 16'h0000, 1'b1, 1'b1);
        run_op("cout_set", 16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0);

        // Reset after the second nibble edge: partial sum and stale cout must vanish.
        a        = 16'h1111;
        b        = 16'h1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_sum", {16'd0, sum}, 32'd0);
        chk("mrst_cout", {31'd0, cout}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 0, 16'h1000, 1'b0, 1'b0);

        // Randomized traffic: operands change every cycle, random valid and ready.
        n_in  = 0;
        n_out = 0;
        cyc   = 0;
        while ((n_in < 1000 || n_out < 1000) && cyc < 40000) begin
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            in_valid  = (n_in < 1000) ? 1'($urandom) : 1'b0;
            out_ready = 1'($urandom);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_output", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    chk("rnd_sum", {16'd0, sum}, {16'd0, e[W-1:0]});
                    chk("rnd_cout", {31'd0, cout}, {31'd0, e[W]});
`ifdef CLA_SEQ_OVF_EN
                    chk("rnd_ovf", {31'd0, ovf}, {31'd0, eo});
`endif
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                r = ref_add(a, b, cin);
                exp_q.push_back(r);
                exp_ovf_q.push_back(ref_ovf(a, b, r[W-1:0]));
                n_in++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_timeout", {31'd0, (cyc >= 40000)}, 32'd0);
        chk("rnd_accepted", n_in, 1000);
        chk("rnd_delivered", n_out, 1000);
        chk("rnd_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
